// File: rtl/ps2_key_sequencer_if.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer_if
// Groups the PS/2 receive-FIFO handshake and the key-event outputs of
// ps2_key_sequencer into one bundle.
//   kb_data     [7:0] FIFO head byte, valid while kb_ready=1
//   kb_ready          FIFO non-empty
//   kb_overflow       FIFO overflow flag
//   kb_rdn            active-low pop strobe (FIFO pops on clk edge when low)
//   key_down    [7:0] held map of the eight movement keys
//   evt_valid         one-cycle pulse, key event presented
//   evt_code    [7:0] final scan-code byte of the event
//   evt_ext           event carried E0
//   evt_break         event carried F0
//   evt_repeat        typematic make of an already-held mapped key
// slave  : the sequencer side.  master : the FIFO / game-logic side.
// ---------------------------------------------------------------------------
interface ps2_key_sequencer_if;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_rdn;
    logic [7:0] key_down;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;

    modport slave (
        input  kb_data, kb_ready, kb_overflow,
        output kb_rdn, key_down, evt_valid, evt_code, evt_ext, evt_break, evt_repeat
    );

    modport master (
        output kb_data, kb_ready, kb_overflow,
        input  kb_rdn, key_down, evt_valid, evt_code, evt_ext, evt_break, evt_repeat
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer
// Drains set-2 scan-code bytes from the PS/2 receive FIFO, parses the
// E0 / F0 / E1 prefix grammar and emits one event per complete key action.
// Also keeps a held-key bitmap for W A S D and the four arrow keys.
//   clk   system clock
//   clrn  asynchronous active-low reset
//   kb    ps2_key_sequencer_if.slave (FIFO handshake in, events/key map out)
// Parameter PAUSE_SKIP: bytes discarded after an E1 prefix.
// Byte cadence is IDLE -> POP -> DECODE, one byte per three cycles.
// ---------------------------------------------------------------------------
module ps2_key_sequencer #(
    parameter int unsigned PAUSE_SKIP = 7
) (
    input  logic                  clk,
    input  logic                  clrn,
    ps2_key_sequencer_if.slave    kb
);

    localparam int unsigned SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DECODE
    } state_e;

    state_e            state_q;
    logic [7:0]        byte_q;
    logic              ext_q;
    logic              brk_q;
    logic [SKIP_W-1:0] skip_q;

    logic              kb_rdn_q;
    logic [7:0]        key_down_q;
    logic              evt_valid_q;
    logic [7:0]        evt_code_q;
    logic              evt_ext_q;
    logic              evt_break_q;
    logic              evt_repeat_q;

    logic [7:0]        map_mask_d;
    logic              is_status_d;

    // Key-map lookup keyed on (ext, code) so plain 75 and E0 1D stay unmapped.
    always_comb begin
        map_mask_d = '0;
        case ({ext_q, byte_q})
            9'h01D:  map_mask_d = 8'h01;
            9'h01C:  map_mask_d = 8'h02;
            9'h023:  map_mask_d = 8'h04;
            9'h01B:  map_mask_d = 8'h08;
            9'h175:  map_mask_d = 8'h10;
            9'h16B:  map_mask_d = 8'h20;
            9'h172:  map_mask_d = 8'h40;
            9'h174:  map_mask_d = 8'h80;
            default: map_mask_d = '0;
        endcase

        is_status_d = 1'b0;
        case (byte_q)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: is_status_d = 1'b1;
            default:                    is_status_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            byte_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            skip_q       <= '0;
            kb_rdn_q     <= 1'b1;
            key_down_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= '0;
            evt_ext_q    <= 1'b0;
            evt_break_q  <= 1'b0;
            evt_repeat_q <= 1'b0;
        end else begin
            evt_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Overflow wins over a pending byte: drop all parse state.
                    if (kb.kb_overflow) begin
                        key_down_q <= '0;
                        ext_q      <= 1'b0;
                        brk_q      <= 1'b0;
                        skip_q     <= '0;
                    end else if (kb.kb_ready) begin
                        state_q  <= POP;
                        kb_rdn_q <= 1'b0;
                    end
                end

                POP: begin
                    byte_q   <= kb.kb_data;
                    kb_rdn_q <= 1'b1;
                    state_q  <= DECODE;
                end

                DECODE: begin
                    state_q <= IDLE;
                    if (skip_q != '0) begin
                        skip_q <= skip_q - SKIP_W'(1);
                    end else if (byte_q == 8'hE1) begin
                        skip_q <= SKIP_W'(PAUSE_SKIP);
                        ext_q  <= 1'b0;
                        brk_q  <= 1'b0;
                    end else if (byte_q == 8'hE0) begin
                        ext_q <= 1'b1;
                    end else if (byte_q == 8'hF0) begin
                        brk_q <= 1'b1;
                    end else if (is_status_d) begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end else begin
                        evt_valid_q  <= 1'b1;
                        evt_code_q   <= byte_q;
                        evt_ext_q    <= ext_q;
                        evt_break_q  <= brk_q;
                        evt_repeat_q <= !brk_q && ((key_down_q & map_mask_d) != '0);
                        if (brk_q) begin
                            key_down_q <= key_down_q & ~map_mask_d;
                        end else begin
                            key_down_q <= key_down_q | map_mask_d;
                        end
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign kb.kb_rdn     = kb_rdn_q;
    assign kb.key_down   = key_down_q;
    assign kb.evt_valid  = evt_valid_q;
    assign kb.evt_code   = evt_code_q;
    assign kb.evt_ext    = evt_ext_q;
    assign kb.evt_break  = evt_break_q;
    assign kb.evt_repeat = evt_repeat_q;

endmodule
